// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Runs the request-to-send sequence, shifts one command byte out on the device clock,
// and reports completion with a one-cycle cmd_done or cmd_error pulse.
// Both lines are open-drain: they are only ever driven low or left floating.
// Optional feature macro: PS2_TX_ACK_CHECK_EN (the device ack must be 0, otherwise error).
module ps2_host_tx #(
    parameter int unsigned CLK_HOLD_CYCLES = 6000,
    parameter int unsigned START_CYCLES    = 64,
    parameter int unsigned TIMEOUT_CYCLES  = 750000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_send,
    output logic       busy,
    output logic       cmd_done,
    output logic       cmd_error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    localparam int unsigned MaxAB  = (CLK_HOLD_CYCLES > START_CYCLES) ? CLK_HOLD_CYCLES
                                                                      : START_CYCLES;
    localparam int unsigned CntMax = (TIMEOUT_CYCLES > MaxAB) ? TIMEOUT_CYCLES : MaxAB;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] HoldLast    = CntW'(CLK_HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] StartLast   = CntW'(START_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StBits,
        StWaitIdle,
        StDone,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            parity_q, parity_d;
    logic            ack_q, ack_d;
    logic            clk_oe_q, clk_oe_d;
    logic            dat_oe_q, dat_oe_d;

    logic [2:0]      clk_sync_q;
    logic [1:0]      dat_sync_q;
    logic            clk_cur, dat_cur, clk_fall;
    logic            ack_bad;

    // Open-drain pads: an active output enable pulls the line low, otherwise it floats.
    assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;

    // Two-flop synchronizers, plus a third clock flop for falling-edge detection.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
        end
    end

    assign clk_cur  = clk_sync_q[1];
    assign dat_cur  = dat_sync_q[1];
    assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];

`ifdef PS2_TX_ACK_CHECK_EN
    assign ack_bad = ack_q;
`else
    // The ack is still captured but a completed frame always counts as done.
    logic unused_ack;
    assign unused_ack = ack_q;
    assign ack_bad    = 1'b0;
`endif

    // State and datapath registers; reset releases both lines immediately.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            parity_q <= 1'b0;
            ack_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            ack_q    <= ack_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    // Next-state logic: request-to-send sequencing, bit shifting and timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        parity_d = parity_q;
        ack_d    = ack_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;

        unique case (state_q)
            StIdle: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (cmd_send) begin
                    data_d   = cmd_data;
                    parity_d = ~^cmd_data;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == HoldLast) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = StStart;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStart: begin
                // Releasing CLK with DAT still low presents the start bit.
                if (cnt_q == StartLast) begin
                    cnt_d    = '0;
                    bit_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = StBits;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBits: begin
                if (clk_fall) begin
                    // bit_q holds edges seen so far; this fall is edge bit_q+1.
                    cnt_d = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q < 4'd8) begin
                        dat_oe_d = ~data_q[bit_q[2:0]];
                    end else if (bit_q == 4'd8) begin
                        dat_oe_d = ~parity_q;
                    end else if (bit_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                    end else begin
                        ack_d    = dat_cur;
                        dat_oe_d = 1'b0;
                        state_d  = StWaitIdle;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = StErr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitIdle: begin
                if (clk_cur && dat_cur) begin
                    state_d = ack_bad ? StErr : StDone;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone, StErr: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                cnt_d    = '0;
                state_d  = StIdle;
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign cmd_done  = (state_q == StDone);
    assign cmd_error = (state_q == StErr);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the clock and collects the frame.
module tb_ps2_host_tx;

    localparam int HOLD  = 60;
    localparam int START = 8;
    localparam int TOUT  = 1500;
    localparam int HALF  = 20;

    logic       clk;
    logic       rst;
    logic [7:0] cmd_data;
    logic       cmd_send;
    wire        busy;
    wire        cmd_done;
    wire        cmd_error;
    wire        ps2_clk;
    wire        ps2_dat;
    logic       dev_clk_low;
    logic       dev_dat_low;

    int n_checks;
    int n_pass;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .CLK_HOLD_CYCLES(HOLD),
        .START_CYCLES   (START),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .cmd_data (cmd_data),
        .cmd_send (cmd_send),
        .busy     (busy),
        .cmd_done (cmd_done),
        .cmd_error(cmd_error),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected line values sampled by the device: {stop, odd parity, byte LSB first}.
    function automatic logic [9:0] model_bits(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, 1'((ones % 2) == 0), b};
    endfunction

    // Pulse cmd_send for one cycle; returns just after the accepting edge.
    task automatic issue(input logic [7:0] b);
        cmd_send = 1'b1;
        cmd_data = b;
        @(posedge clk);
        #1 cmd_send = 1'b0;
    endtask

    // Counts the host's CLK-low window; returns at the first cycle with CLK released.
    task automatic measure(output int low_cnt, output int dat_at);
        low_cnt = 0;
        dat_at  = -1;
        for (int i = 0; i < 4 * (HOLD + START) + 100; i++) begin
            @(negedge clk);
            if (ps2_clk !== 1'b0) break;
            if (ps2_dat === 1'b0 && dat_at < 0) dat_at = low_cnt;
            low_cnt++;
        end
    endtask

    // Device side: generates up to 11 clocks; abort_at leaves CLK low after that edge.
    task automatic dev_frame(input bit ack_val, input int abort_at, output logic [9:0] obs);
        obs = '0;
        for (int n = 1; n <= 11; n++) begin
            if (n == 11) dev_dat_low = ~ack_val;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (n == abort_at) return;
            if (n <= 10) obs[n-1] = ps2_dat;
            dev_clk_low = 1'b0;
        end
        dev_dat_low = 1'b0;
    endtask

    // Waits for the result pulse; returns at the cycle after it.
    task automatic wait_pulse(output bit d, output bit e);
        d = 1'b0;
        e = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmd_done || cmd_error) break;
        end
        d = cmd_done;
        e = cmd_error;
        chk("busy_in_pulse", 32'(busy), 32'd1);
        @(negedge clk);
        chk("pulse_width", 32'({cmd_done, cmd_error}), 32'd0);
        chk("busy_after_pulse", 32'(busy), 32'd0);
    endtask

    // One full transaction after issue(): inhibit timing, frame contents and result.
    task automatic frame(input logic [7:0] b, input bit ack_val, input bit exp_err,
                         input bit extra_send);
        int          low_cnt;
        int          dat_at;
        logic [9:0]  obs;
        bit          d;
        bit          e;
        @(negedge clk);
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_clk_low", 32'(ps2_clk), 32'd0);
        measure(low_cnt, dat_at);
        chk("clk_low_cycles", 32'(low_cnt + 1), 32'(HOLD + START));
        chk("dat_fall_offset", 32'(dat_at + 1), 32'(HOLD));
        chk("start_bit", 32'(ps2_dat), 32'd0);
        if (extra_send) begin
            cmd_send = 1'b1;
            cmd_data = 8'h55;
            @(posedge clk);
            #1 cmd_send = 1'b0;
        end
        dev_frame(ack_val, 0, obs);
        chk("frame_bits", 32'(obs), 32'(model_bits(b)));
        wait_pulse(d, e);
        chk("result", 32'({d, e}), exp_err ? 32'd1 : 32'd2);
    endtask

    initial begin
        int          low_cnt;
        int          dat_at;
        int          cnt;
        int          bad;
        bit          ack_err;
        logic [7:0]  rb;
        logic [9:0]  obs;

        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        cmd_send    = 1'b0;
        cmd_data    = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", 32'({cmd_done, cmd_error}), 32'd0);
        chk("rst_lines", 32'({ps2_clk, ps2_dat}), 32'd3);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Set-LEDs command, normal ack.
        issue(8'hED);
        frame(8'hED, 1'b0, 1'b0, 1'b0);

        // Back-to-back: second request in the cycle right after the done pulse.
        issue(8'h01);
        frame(8'h01, 1'b0, 1'b0, 1'b0);
        issue(8'hFF);
        frame(8'hFF, 1'b0, 1'b0, 1'b0);

        // Random command bytes.
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom_range(0, 255));
            repeat (3) @(negedge clk);
            issue(rb);
            frame(rb, 1'b0, 1'b0, 1'b0);
        end

        // No device clock after the request: timeout error.
        repeat (3) @(negedge clk);
        issue(8'($urandom_range(0, 255)));
        @(negedge clk);
        measure(low_cnt, dat_at);
        cnt = 0;
        for (int i = 0; i < 2 * TOUT + 10; i++) begin
            @(negedge clk);
            cnt++;
            if (cmd_error) break;
        end
        chk("timeout_cycles", 32'(cnt), 32'(TOUT));
        chk("timeout_lines", 32'({ps2_clk, ps2_dat}), 32'd3);
        @(negedge clk);
        chk("timeout_busy_after", 32'(busy), 32'd0);

        // Ack held high.
`ifdef PS2_TX_ACK_CHECK_EN
        ack_err = 1'b1;
`else
        ack_err = 1'b0;
`endif
        repeat (3) @(negedge clk);
        issue(8'hF4);
        frame(8'hF4, 1'b1, ack_err, 1'b0);

        // Reset at data edge 5.
        repeat (3) @(negedge clk);
        issue(8'($urandom_range(0, 255)));
        @(negedge clk);
        measure(low_cnt, dat_at);
        dev_frame(1'b0, 5, obs);
        dev_clk_low = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_lines", 32'({ps2_clk, ps2_dat}), 32'd3);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_done || cmd_error || busy) bad++;
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_done || cmd_error || busy) bad++;
        end
        chk("midrst_quiet", 32'(bad), 32'd0);

        // Request while busy is ignored: only 0xF4 goes out, nothing follows.
        issue(8'hF4);
        frame(8'hF4, 1'b0, 1'b0, 1'b1);
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (busy || ps2_clk !== 1'b1) bad++;
        end
        chk("no_queued_cmd", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for the PS/2 port. It sends one command byte, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), to the attached keyboard. It follows the PS/2 request-to-send sequence, open-drain drives PS2_CLK/PS2_DAT, and reports done or error. It shares the PS2_CLK/PS2_DAT pins with the scancode receive path; game logic issues commands through it.

## Interface
- CLK_HOLD_CYCLES, 6000, CLOCK_50 cycles PS2_CLK is held low to inhibit the device (120 us)
- START_CYCLES, 64, cycles both lines are held low before PS2_CLK is released
- TIMEOUT_CYCLES, 750000, max cycles waited for any expected device clock edge or line release (15 ms)
- CLOCK_50  input  1  system clock, all logic on posedge
- reset  input  1  asynchronous, active-high; returns block to IDLE, releases both lines
- cmd_data  input  8  byte to send, captured on accepted cmd_send
- cmd_send  input  1  one-cycle request; accepted only when busy==0
- busy  output  1  high from cycle after acceptance until done/error pulse cycle inclusive
- cmd_done  output  1  one-cycle pulse: byte sent, ack received
- cmd_error  output  1  one-cycle pulse: timeout or missing ack
- PS2_CLK  inout  1  open-drain: driven 0 or Z
- PS2_DAT  inout  1  open-drain: driven 0 or Z

## Operation
- Inputs PS2_CLK/PS2_DAT pass through 2-flop synchronizers; a third flop on clock gives fall = prev & ~cur.
- Frame: start 0, d[0..7] LSB first, odd parity (~^d), stop 1, device ack 0.
- States:
  - IDLE: lines Z. cmd_send -> latch byte, compute parity, go to INHIBIT.
  - INHIBIT: CLK driven 0 for CLK_HOLD_CYCLES, DAT Z -> START.
  - START: CLK 0, DAT 0 for START_CYCLES -> REQ. CLK is released on REQ entry; DAT stays 0 (start bit).
  - REQ/BITS: a bit counter n counts synchronized falling edges 1..11.
    - Edges 1-8: DAT = d[n-1] (0 drives, 1 releases).
    - Edge 9: DAT = parity.
    - Edge 10: release DAT (stop).
    - Edge 11: sample DAT as ack -> WAIT_IDLE.
  - WAIT_IDLE: wait until synced CLK and DAT are both 1 -> DONE, or ERR if the ack failed.
  - DONE / ERR: one cycle, pulse the matching output -> IDLE.
- Timeout counter: cleared on REQ entry, on every falling edge and on WAIT_IDLE entry. Reaching TIMEOUT_CYCLES in REQ/BITS or WAIT_IDLE -> ERR; lines are released the same cycle.
- cmd_send while busy: ignored, no queueing.
- Reset mid-operation: lines go Z immediately (async). No done/error pulse. Latched byte is discarded.

## Timing
- Reset values: busy 0, cmd_done 0, cmd_error 0, PS2_CLK Z, PS2_DAT Z, state IDLE, counters 0.
- Acceptance at edge k: busy=1 and CLK driven 0 from k+1.
- CLK is low exactly CLK_HOLD_CYCLES+START_CYCLES cycles. DAT goes low CLK_HOLD_CYCLES cycles after CLK.
- DAT updates 3 CLOCK_50 cycles after the pin falling edge (sync + edge detect). This is far inside the ~half-period of a 10-16.7 kHz PS/2 clock.
- cmd_done/cmd_error are high exactly one cycle; busy falls the next cycle. A new cmd_send is accepted in that next cycle.
- Bit counter is 4 bits and never wraps: edges beyond 11 are ignored outside REQ/BITS.

## Configuration
- PS2_TX_ACK_CHECK_EN defined: ack sampled at edge 11 must be 0, otherwise ERR (cmd_error after line release).
- Not defined: ack value is ignored; a completed frame always ends in DONE. The timeout still applies.

## Test plan
- Device model clocks at 12.5 kHz, cmd_data=0xED -> pin bits 1,0,1,1,0,1,1,1, parity 1, stop 1; ack 0 -> cmd_done one pulse, busy 0 next cycle.
- cmd_data=0x01 then 0xFF back-to-back (second cmd_send in cycle after done) -> parity 0 then 1; both frames complete.
- Check inhibit: CLK low 6064 cycles total; DAT falls at cycle 6000 after CLK fall; CLK Z afterwards.
- No device clock after request -> cmd_error pulse exactly 750000 cycles after REQ entry; both lines Z.
- Ack held 1 with PS2_TX_ACK_CHECK_EN -> cmd_error; same stimulus without macro -> cmd_done.
- Assert reset at data edge 5 -> lines Z, busy 0 immediately, no pulses. cmd_send while busy (0x55 during 0xF4) -> only 0xF4 transmitted.
